// File: rtl/score_digit_formatter.sv
// Builds the eight digit codes for seg_display: a sequential double-dabble score
// conversion with leading-zero blanking, plus the registered note/octave/mode digits.
module score_digit_formatter #(
  parameter int unsigned SCORE_W   = 14,
  parameter int unsigned SCORE_MAX = 9999,
  parameter logic [3:0]  BLANK     = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [13:0]  score,
  input  logic [3:0]   note,
  input  logic [1:0]   octave,
  input  logic [3:0]   mode,
  output logic [3:0]   p0,
  output logic [3:0]   p1,
  output logic [3:0]   p2,
  output logic [3:0]   p3,
  output logic [3:0]   p4,
  output logic [3:0]   p5,
  output logic [3:0]   p6,
  output logic [3:0]   p7,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = $clog2(SCORE_W + 1);
  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SCORE_W-1:0] sh, sh_n;
  logic [BCD_W-1:0]   bcd, bcd_n, bcd_adj;
  logic               pend, pend_n;
  logic [SCORE_W-1:0] pval, pval_n;
  logic [BCD_W-1:0]   disp, disp_n, disp_blank;
  logic               done_n, busy_n;
  logic [SCORE_W-1:0] sat_score;
  logic [BCD_W+SCORE_W-1:0] shifted;

  assign sat_score = (score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score;

  // Per-nibble add-3 correction; nibbles stay <= 9 so the result never exceeds 12 (no carry out).
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj[BCD_W-2:0], sh, 1'b0};

  // Leading zeros among thousands/hundreds/tens are blanked; ones always shown.
  always_comb begin
    disp_blank = bcd;
    if (bcd[15:12] == 4'd0) begin
      disp_blank[15:12] = BLANK;
      if (bcd[11:8] == 4'd0) begin
        disp_blank[11:8] = BLANK;
        if (bcd[7:4] == 4'd0) disp_blank[7:4] = BLANK;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    bcd_n   = bcd;
    pend_n  = pend;
    pval_n  = pval;
    disp_n  = disp;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sh_n    = sat_score;
          bcd_n   = '0;
          cnt_n   = CNT_W'(SCORE_W);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bcd_n = shifted[BCD_W+SCORE_W-1:SCORE_W];
        sh_n  = shifted[SCORE_W-1:0];
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = FINISH;
      end
      FINISH: begin
        disp_n = disp_blank;
        done_n = 1'b1;
        if (pend) begin
          sh_n    = pval;
          bcd_n   = '0;
          cnt_n   = CNT_W'(SCORE_W);
          pend_n  = 1'b0;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A load outside IDLE (including FINISH) overwrites the single pending slot.
    if (load && state != IDLE) begin
      pend_n = 1'b1;
      pval_n = sat_score;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      bcd   <= '0;
      pend  <= 1'b0;
      pval  <= '0;
      disp  <= {4{BLANK}};
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      bcd   <= bcd_n;
      pend  <= pend_n;
      pval  <= pval_n;
      disp  <= disp_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  // Status digits follow their inputs with one cycle of latency, regardless of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= BLANK;
      p1 <= BLANK;
      p2 <= BLANK;
      p3 <= BLANK;
    end else begin
      p0 <= note;
      p1 <= {2'b00, octave};
      p2 <= BLANK;
      p3 <= mode;
    end
  end

  assign p4 = disp[15:12];
  assign p5 = disp[11:8];
  assign p6 = disp[7:4];
  assign p7 = disp[3:0];

endmodule
